// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: holds the trap CSRs, sequences trap entry
// (SAVE then VECTOR) and trap return (RETURN), and drives the fetch
// redirect / stall controls for the pipeline.
module trap_ctrl #(
   parameter logic [31:0] MTVEC_RST = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ecall,
   input  logic        ebreak,
   input  logic        mret,
   input  logic        irq_ext,
   input  logic        irq_timer,
   input  logic [31:0] pc_in,
   input  logic        csr_we,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        stall
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

   localparam logic [31:0] CAUSE_ECALL  = 32'd11;
   localparam logic [31:0] CAUSE_EBREAK = 32'd3;
   localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
   localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAVE   = 2'd1,
      VECTOR = 2'd2,
      RETURN = 2'd3
   } state_t;

   state_t      state_reg, state_next;

   // Only the implemented bits of mstatus/mie are stored; the rest read as 0.
   logic        status_mie_reg;
   logic        status_mpie_reg;
   logic        ie_meie_reg;
   logic        ie_mtie_reg;
   logic [31:0] mtvec_reg;
   logic [31:0] mepc_reg;
   logic [31:0] mcause_reg;

   // Trap context latched when leaving IDLE, committed to mepc/mcause at SAVE exit,
   // so a pc_in change while stalled cannot corrupt mepc.
   logic [31:0] trap_pc_reg;
   logic [31:0] trap_cause_reg;
   logic [31:0] trap_cause_next;
   logic        take_trap;

   logic        ext_pending;
   logic        timer_pending;

   assign ext_pending   = irq_ext   & status_mie_reg & ie_meie_reg;
   assign timer_pending = irq_timer & status_mie_reg & ie_mtie_reg;

   // Event selection, next state and state-decoded pipeline controls.
   always_comb begin
      state_next      = state_reg;
      take_trap       = 1'b0;
      trap_cause_next = trap_cause_reg;
      redirect        = 1'b0;
      redirect_pc     = 32'h0;
      stall           = 1'b0;
      case (state_reg)
         IDLE: begin
            if (ecall) begin
               take_trap       = 1'b1;
               trap_cause_next = CAUSE_ECALL;
            end else if (ebreak) begin
               take_trap       = 1'b1;
               trap_cause_next = CAUSE_EBREAK;
            end else if (mret) begin
               state_next = RETURN;
            end else if (ext_pending) begin
               take_trap       = 1'b1;
               trap_cause_next = CAUSE_EXT;
            end else if (timer_pending) begin
               take_trap       = 1'b1;
               trap_cause_next = CAUSE_TIMER;
            end
            if (take_trap) begin
               state_next = SAVE;
            end
         end
         SAVE: begin
            stall      = 1'b1;
            state_next = VECTOR;
         end
         VECTOR: begin
            redirect    = 1'b1;
            redirect_pc = {mtvec_reg[31:2], 2'b00};
            state_next  = IDLE;
         end
         RETURN: begin
            redirect    = 1'b1;
            redirect_pc = mepc_reg;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Latch trap PC and cause at the IDLE->SAVE transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         trap_pc_reg    <= 32'h0;
         trap_cause_reg <= 32'h0;
      end else if (take_trap) begin
         trap_pc_reg    <= pc_in;
         trap_cause_reg <= trap_cause_next;
      end
   end

   // CSR updates: software writes first, hardware trap/return updates last so they win.
   always_ff @(posedge clk) begin
      if (rst) begin
         status_mie_reg  <= 1'b0;
         status_mpie_reg <= 1'b0;
         ie_meie_reg     <= 1'b0;
         ie_mtie_reg     <= 1'b0;
         mtvec_reg       <= MTVEC_RST;
         mepc_reg        <= 32'h0;
         mcause_reg      <= 32'h0;
      end else begin
         if (csr_we) begin
            case (csr_addr)
               ADDR_MSTATUS: begin
                  status_mie_reg  <= csr_wdata[3];
                  status_mpie_reg <= csr_wdata[7];
               end
               ADDR_MIE: begin
                  ie_mtie_reg <= csr_wdata[7];
                  ie_meie_reg <= csr_wdata[11];
               end
               ADDR_MTVEC:  mtvec_reg  <= csr_wdata;
               ADDR_MEPC:   mepc_reg   <= csr_wdata & ~32'h3;
               ADDR_MCAUSE: mcause_reg <= csr_wdata;
               default: ;
            endcase
         end
         if (state_reg == SAVE) begin
            mepc_reg        <= trap_pc_reg & ~32'h3;
            mcause_reg      <= trap_cause_reg;
            status_mpie_reg <= status_mie_reg;
            status_mie_reg  <= 1'b0;
         end
         if (state_reg == RETURN) begin
            status_mie_reg  <= status_mpie_reg;
            status_mpie_reg <= 1'b1;
         end
      end
   end

   // Combinational CSR read port.
   always_comb begin
      csr_rdata = 32'h0;
      case (csr_addr)
         ADDR_MSTATUS: csr_rdata = {24'h0, status_mpie_reg, 3'b000, status_mie_reg, 3'b000};
         ADDR_MIE:     csr_rdata = {20'h0, ie_meie_reg, 3'b000, ie_mtie_reg, 7'h00};
         ADDR_MTVEC:   csr_rdata = mtvec_reg;
         ADDR_MEPC:    csr_rdata = mepc_reg;
         ADDR_MCAUSE:  csr_rdata = mcause_reg;
         default:      csr_rdata = 32'h0;
      endcase
   end

endmodule
